at_cmd_uart_tx: RTL and testbench

Serializes the 144-bit packed AT command produced by the Bluetooth command encoder onto the UART line to the BLE module. Consumes the encoder's `output_data` byte by byte, byte 0 (`[7:0]`) first, as 8N1 frames. Transmission stops at the first 0x00 byte or after 18 bytes. It honours the module's CTS flow control between bytes and reports completion with a one-cycle `done` pulse.

---
 rtl/at_cmd_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_at_cmd_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/at_cmd_uart_tx.sv
`timescale 1ns/1ps
// at_cmd_uart_tx: sends a latched 144-bit AT command as 8N1 UART frames, byte 0 first,
//   stopping at the first 0x00 byte or after 18 bytes.
// Latency: start bit begins 1 cycle after send is accepted; each byte costs 1 + 10*CLKS_PER_BIT cycles.
// Backpressure: cts_n (active-low) is sampled only between frames; while high the next frame waits
//   indefinitely, a frame already started always completes.
//
// Ports:
//   clk, reset    - clock (rising edge) and asynchronous active-high reset
//   cmd_data      - packed command, byte k at [8k+7:8k]; captured when send is accepted
//   send          - start request, honoured only while idle
//   cts_n         - clear-to-send from the BLE module, active-low
//   tx            - UART serial line, idles high
//   busy          - high from send acceptance until completion
//   done          - one-cycle completion pulse
//   bytes_sent    - frames fully transmitted for the current/last command
module at_cmd_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [143:0] cmd_data,
    input  logic         send,
    input  logic         cts_n,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [4:0]   bytes_sent
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]     MAX_BYTES = 5'd18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         state_q, state_d;
    logic [143:0]   buf_q, buf_d;       // current byte always sits in buf_q[7:0]
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_q, bit_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [4:0]     sent_q, sent_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sent_d  = sent_q;

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (send) begin
                    buf_d   = cmd_data;
                    idx_d   = '0;
                    sent_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                tx_d = 1'b1;
                // Terminator check comes before flow control so an empty
                // remainder finishes even while the module holds off.
                if (idx_q == MAX_BYTES || buf_q[7:0] == 8'h00) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!cts_n) begin
                    shift_d = buf_q[7:0];
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    sent_d  = sent_q + 1'b1;
                    idx_d   = idx_q + 1'b1;
                    buf_d   = {8'h00, buf_q[143:8]};
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bytes_sent = sent_q;

endmodule

// File: tb/tb_at_cmd_uart_tx.sv
`timescale 1ns/1ps
module tb_at_cmd_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 1 + 10 * CPB;

    logic         clk = 1'b0;
    logic         reset;
    logic [143:0] cmd_data;
    logic         send;
    logic         cts_n;
    logic         tx;
    logic         busy;
    logic         done;
    logic [4:0]   bytes_sent;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int e0     = 0;

    at_cmd_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .send       (send),
        .cts_n      (cts_n),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART line monitor: samples every cycle on the falling edge, so each
    // 10-bit frame is exactly 40 samples; every bit slot must be constant.
    logic       mon_act = 1'b0;
    int         mon_n   = 0;
    int         mon_s   = 0;
    logic [39:0] mon_smp;
    logic       mon_ok;
    logic [7:0] mon_b;
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         frame_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act    = 1'b1;
                mon_smp    = '0;
                mon_smp[0] = tx;
                mon_n      = 1;
                mon_s      = cyc;
            end
        end else begin
            mon_smp[mon_n] = tx;
            mon_n++;
            if (mon_n == 40) begin
                mon_act = 1'b0;
                mon_ok  = (mon_smp[0] === 1'b0) && (mon_smp[36] === 1'b1);
                for (int j = 0; j < 10; j++)
                    for (int k = 1; k < 4; k++)
                        if (mon_smp[4*j+k] !== mon_smp[4*j]) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) mon_b[i] = mon_smp[4*(i+1)];
                if (mon_ok) begin
                    rx_q.push_back(mon_b);
                    rx_start_q.push_back(mon_s);
                end else begin
                    frame_err++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frames sent = bytes before first zero, capped at 18.
    function automatic int ref_count(input logic [143:0] d);
        for (int k = 0; k < 18; k++)
            if (d[8*k +: 8] == 8'h00) return k;
        return 18;
    endfunction

    function automatic logic [143:0] str_cmd(input string s);
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 18; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [143:0] rand_cmd();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[143:0];
    endfunction

    // Returns at the falling edge after edge 0; e0 marks edge 0.
    task automatic start_cmd(input logic [143:0] d);
        @(negedge clk);
        rx_q.delete();
        rx_start_q.delete();
        frame_err = 0;
        cmd_data  = d;
        send      = 1'b1;
        @(negedge clk);
        send     = 1'b0;
        e0       = cyc;
        cmd_data = rand_cmd();
    endtask

    task automatic finish_cmd(input string tag, input logic [143:0] d,
                              input int extra, input int stall_from);
        int n;
        int exp_done;
        int rel;
        int exp_start;
        n        = ref_count(d);
        exp_done = (n == 0) ? 1 : 1 + n * FRAME + extra;
        rel      = -1;
        check({tag, " busy_in_flight"}, busy, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin
                rel = cyc - e0;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done_edge"}, rel, exp_done);
        check({tag, " busy_at_done"}, busy, 1'b0);
        check({tag, " bytes_sent"}, bytes_sent, n);
        check({tag, " frame_errors"}, frame_err, 0);
        check({tag, " frame_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            exp_start = 1 + i * FRAME + ((i >= stall_from) ? extra : 0);
            check($sformatf("%s byte%0d", tag, i), rx_q[i], d[8*i +: 8]);
            check($sformatf("%s start%0d", tag, i), rx_start_q[i] - e0, exp_start);
        end
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 1'b0);
        check({tag, " bytes_sent_hold"}, bytes_sent, n);
    endtask

    initial begin
        logic [143:0] d1;
        logic [143:0] d2;
        logic [143:0] d3;
        logic [143:0] dr;
        int z;
        int stall;

        reset    = 1'b1;
        send     = 1'b0;
        cts_n    = 1'b0;
        cmd_data = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset bytes_sent", bytes_sent, 5'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        d1 = str_cmd("AT+BLEUARTTX=1234\r");
        d2 = str_cmd("AT+BLEUARTRX\r");

        // Full 18-byte command.
        start_cmd(d1);
        finish_cmd("tx18", d1, 0, 0);

        // Terminated by zero padding.
        start_cmd(d2);
        finish_cmd("rx13", d2, 0, 0);

        // Empty command.
        d3 = rand_cmd();
        d3[7:0] = 8'h00;
        start_cmd(d3);
        finish_cmd("empty", d3, 0, 0);

        // Flow control: 20-cycle hold-off before byte 3, cts_n toggling in byte 5.
        start_cmd(d1);
        repeat (123) @(negedge clk);
        cts_n = 1'b1;
        repeat (20) @(negedge clk);
        cts_n = 1'b0;
        repeat (88) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            cts_n = ~cts_n;
            @(negedge clk);
        end
        cts_n = 1'b0;
        finish_cmd("cts", d1, 20, 3);

        // Protocol abuse: resend mid-byte 2, then reset during byte 4 data.
        start_cmd(d1);
        repeat (93) @(negedge clk);
        cmd_data = rand_cmd();
        send     = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (86) @(negedge clk);
        check("abuse bytes_sent_before_reset", bytes_sent, 5'd4);
        check("abuse busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("abuse reset tx", tx, 1'b1);
        check("abuse reset busy", busy, 1'b0);
        check("abuse reset bytes_sent", bytes_sent, 5'd0);
        check("abuse reset done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abuse no_done%0d", i), done, 1'b0);
        end
        reset = 1'b0;
        check("abuse frames_before_reset", rx_q.size(), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++)
            check($sformatf("abuse byte%0d", i), rx_q[i], d1[8*i +: 8]);
        start_cmd(d2);
        finish_cmd("after_reset", d2, 0, 0);

        // Randomized commands with random terminator position and CTS hold-off.
        for (int t = 0; t < 6; t++) begin
            z     = $urandom_range(0, 18);
            stall = $urandom_range(0, 15);
            dr    = '0;
            for (int k = 0; k < 18; k++) begin
                if (k < z)       dr[8*k +: 8] = 8'($urandom_range(1, 255));
                else if (k == z) dr[8*k +: 8] = 8'h00;
                else             dr[8*k +: 8] = 8'($urandom_range(0, 255));
            end
            cts_n = 1'b1;
            start_cmd(dr);
            repeat (stall) @(negedge clk);
            cts_n = 1'b0;
            finish_cmd($sformatf("rand%0d", t), dr, stall, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
